// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: default geometry,
// the hex font and the all-segments-off pattern.
package seg7_pkg;

  localparam int DEFAULT_DIGITS       = 8;
  localparam int DEFAULT_REFRESH_DIV  = 100000;
  localparam int DEFAULT_GUARD_CYCLES = 16;

  // Active-low cathode pattern with every segment dark.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex font, segments {g,f,e,d,c,b,a}, active-high (1 = segment lit).
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low seven-segment cathode pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Font lookup, inverted for common-anode cathodes.
  assign seg_n = ~HEX_FONT[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver for an 8-digit common-anode
// seven-segment display. A loaded value waits in a pending register and is
// committed to the displayed shadow copy only at a frame boundary, so a frame
// never mixes old and new digits. Each digit slot opens with a guard window
// with all anodes off to suppress ghosting.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = DEFAULT_DIGITS,
  parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
  parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  load_i,
  input  logic [DIGITS-1:0]     en_i,
  input  logic [DIGITS-1:0]     dp_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic                slot_end;
  logic                commit;

  logic [4*DIGITS-1:0] pending;
  logic                pend_flag;
  logic [4*DIGITS-1:0] shadow;

  logic [3:0]          nibble;
  logic [6:0]          font_seg;
  logic [DIGITS-1:0]   onehot;
  logic                in_guard;
  logic                blank;

  logic [DIGITS-1:0]   an_next;
  logic [6:0]          seg_next;
  logic                dp_next;

  assign slot_end = (div_cnt == CNT_LAST);
  assign commit   = slot_end && (idx == IDX_LAST);
  assign in_guard = (div_cnt < GUARD_END);

  // Slot timer and digit index; the index wrap is the frame boundary.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (slot_end) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Pending capture and frame-boundary commit into the displayed shadow copy.
  // NOTE: pending and shadow are ordinary registers (not a RAM), so they take
  // the reset; a reset mid-frame must discard a queued load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending   <= '0;
      pend_flag <= 1'b0;
      shadow    <= '0;
    end else begin
      if (load_i) begin
        pending <= value_i;
      end
      if (commit) begin
        if (load_i) begin
          shadow <= value_i;
        end else if (pend_flag) begin
          shadow <= pending;
        end
        pend_flag <= 1'b0;
      end else if (load_i) begin
        pend_flag <= 1'b1;
      end
    end
  end

  assign nibble = shadow[{idx, 2'b00} +: 4];
  assign onehot = DIGITS'(1) << idx;

  hex_to_seg7 u_font (
    .nibble (nibble),
    .seg_n  (font_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] msd;

  // Position of the most significant nonzero nibble; digit 0 if all zero.
  always_comb begin
    msd = '0;
    for (int d = 1; d < DIGITS; d++) begin
      if (shadow[4*d +: 4] != 4'h0) begin
        msd = IDX_W'(d);
      end
    end
  end

  assign blank = (idx > msd);
`else
  assign blank = 1'b0;
`endif

  // Next output pattern: cathodes lead the anode so the guard window
  // already carries the new digit's segments.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    an_next  = '1;
    seg_next = font_seg;
    dp_next  = ~dp_i[idx];
    if (blank) begin
      seg_next = SEG_BLANK;
      dp_next  = 1'b1;
    end else if (!in_guard) begin
      an_next = ~(onehot & en_i);
    end
  end

  // Registered display outputs, all dark in reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      an_o  <= '1;
      seg_o <= SEG_BLANK;
      dp_o  <= 1'b1;
    end else begin
      an_o  <= an_next;
      seg_o <= seg_next;
      dp_o  <= dp_next;
    end
  end

endmodule
